// File: rtl/id_ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_pkg
// Description : Shared core types for the ID/EX stage: forward-select
//               encoding, the EX control bundle and the forwarding rule.
// Revision    : 1.0 - initial release
// ============================================================================
package id_ex_stage_pkg;

    localparam int C_REG_ADDR_W = 5;

    // Source selected for one ALU operand after hazard resolution
    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    // Control fields carried through the EX register
    typedef struct packed {
        logic [2:0] funct3;
        logic       funct7_6;
        logic       branch;
        logic       useF7;
        logic       useRegAdd;
        logic       selPc;
        logic       selImm;
        logic       regWrite;
        logic       memRead;
        logic       memWrite;
    } ex_ctrl_t;

    // Youngest producer wins; x0 is hard-wired zero and never forwarded
    function automatic fwd_sel_e fwd_select(
        input logic                    mem_we,
        input logic [C_REG_ADDR_W-1:0] mem_rd,
        input logic                    wb_we,
        input logic [C_REG_ADDR_W-1:0] wb_rd,
        input logic [C_REG_ADDR_W-1:0] rs
    );
        if (mem_we && (mem_rd != '0) && (mem_rd == rs)) begin
            return FWD_MEM;
        end else if (wb_we && (wb_rd != '0) && (wb_rd == rs)) begin
            return FWD_WB;
        end
        return FWD_REG;
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_if
// Description : Bundle of decode inputs, forwarding inputs, redirect and
//               ALU-side outputs of the ID/EX stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface id_ex_if #(
    parameter int XLEN = 32
);

    // Decode side
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [4:0]      id_rd;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [2:0]      id_funct3;
    logic            id_funct7_6;
    logic            id_branch;
    logic            id_useF7;
    logic            id_useRegAdd;
    logic            id_selPc;
    logic            id_selImm;
    logic            id_regWrite;
    logic            id_memRead;
    logic            id_memWrite;

    // Forwarding sources
    logic [4:0]      mem_rd;
    logic            mem_regWrite;
    logic [XLEN-1:0] mem_result;
    logic [4:0]      wb_rd;
    logic            wb_regWrite;
    logic [XLEN-1:0] wb_result;

    // Redirect / hazard
    logic            flush;
    logic            stall;

    // ALU side
    logic [XLEN-1:0] srcA;
    logic [XLEN-1:0] srcB;
    logic [2:0]      funct3;
    logic            funct7_6;
    logic            branch;
    logic            useF7;
    logic            useRegAdd;

    // Pass-through to later stages
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [4:0]      ex_rd;
    logic            ex_regWrite;
    logic            ex_memRead;
    logic            ex_memWrite;
    logic [XLEN-1:0] ex_storeData;

    modport master (
        output id_valid, id_pc, id_rs1, id_rs2, id_rd,
               id_rs1_data, id_rs2_data, id_imm, id_funct3, id_funct7_6,
               id_branch, id_useF7, id_useRegAdd, id_selPc, id_selImm,
               id_regWrite, id_memRead, id_memWrite,
               mem_rd, mem_regWrite, mem_result,
               wb_rd, wb_regWrite, wb_result, flush,
        input  stall, srcA, srcB, funct3, funct7_6, branch, useF7, useRegAdd,
               ex_valid, ex_pc, ex_rd, ex_regWrite, ex_memRead, ex_memWrite,
               ex_storeData
    );

    modport slave (
        input  id_valid, id_pc, id_rs1, id_rs2, id_rd,
               id_rs1_data, id_rs2_data, id_imm, id_funct3, id_funct7_6,
               id_branch, id_useF7, id_useRegAdd, id_selPc, id_selImm,
               id_regWrite, id_memRead, id_memWrite,
               mem_rd, mem_regWrite, mem_result,
               wb_rd, wb_regWrite, wb_result, flush,
        output stall, srcA, srcB, funct3, funct7_6, branch, useF7, useRegAdd,
               ex_valid, ex_pc, ex_rd, ex_regWrite, ex_memRead, ex_memWrite,
               ex_storeData
    );

endinterface
`default_nettype wire

// File: rtl/id_ex_stage_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module      : fwd_mux
// Description : Operand bypass for one source register: picks EX/MEM result,
//               MEM/WB result or the registered register-file value.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_mux
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  wire logic [4:0]      i_rs,
    input  wire logic [XLEN-1:0] i_reg_data,
    input  wire logic [4:0]      i_mem_rd,
    input  wire logic            i_mem_regWrite,
    input  wire logic [XLEN-1:0] i_mem_result,
    input  wire logic [4:0]      i_wb_rd,
    input  wire logic            i_wb_regWrite,
    input  wire logic [XLEN-1:0] i_wb_result,
    output logic      [XLEN-1:0] o_data
);

    fwd_sel_e w_sel;

    assign w_sel = fwd_select(i_mem_regWrite, i_mem_rd, i_wb_regWrite, i_wb_rd, i_rs);

    // Operand select driven by the priority rule in the package
    always_comb begin
        o_data = i_reg_data;
        case (w_sel)
            FWD_MEM: o_data = i_mem_result;
            FWD_WB:  o_data = i_wb_result;
            default: o_data = i_reg_data;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with load-use stall detection,
//               redirect flush and two-level operand forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input wire logic clk,
    input wire logic rst,
    id_ex_if.slave   bus
);

    // EX register
    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [XLEN-1:0] r_imm;
    ex_ctrl_t        r_ctrl;

    logic            w_hazard;
    logic            w_stall;
    logic            w_bubble;
    ex_ctrl_t        w_next_ctrl;
    logic [XLEN-1:0] w_fwd_a;
    logic [XLEN-1:0] w_fwd_b;

    // Load in EX whose destination is read by the instruction in ID
    assign w_hazard = bus.id_valid && r_valid && r_ctrl.memRead && (r_rd != 5'd0) &&
                      ((r_rd == bus.id_rs1) || (r_rd == bus.id_rs2));

    // A redirect kills the dependent instruction anyway, so never stall on it;
    // reset likewise suppresses the stall so no extra cycle leaks out of it.
    assign w_stall  = w_hazard && !bus.flush && !rst;
    assign w_bubble = bus.flush || w_stall || !bus.id_valid;

    // Next control bundle: decode fields, with side-effecting controls killed on a bubble
    always_comb begin
        w_next_ctrl           = '0;
        w_next_ctrl.funct3    = bus.id_funct3;
        w_next_ctrl.funct7_6  = bus.id_funct7_6;
        w_next_ctrl.branch    = bus.id_branch;
        w_next_ctrl.useF7     = bus.id_useF7;
        w_next_ctrl.useRegAdd = bus.id_useRegAdd;
        w_next_ctrl.selPc     = bus.id_selPc;
        w_next_ctrl.selImm    = bus.id_selImm;
        w_next_ctrl.regWrite  = bus.id_regWrite;
        w_next_ctrl.memRead   = bus.id_memRead;
        w_next_ctrl.memWrite  = bus.id_memWrite;
        if (w_bubble) begin
            w_next_ctrl.branch   = 1'b0;
            w_next_ctrl.regWrite = 1'b0;
            w_next_ctrl.memRead  = 1'b0;
            w_next_ctrl.memWrite = 1'b0;
        end
    end

    // EX register update; reset outranks flush and stall
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_ctrl     <= '0;
        end else begin
            r_valid    <= bus.id_valid && !w_bubble;
            r_pc       <= bus.id_pc;
            r_rs1      <= bus.id_rs1;
            r_rs2      <= bus.id_rs2;
            r_rd       <= bus.id_rd;
            r_rs1_data <= bus.id_rs1_data;
            r_rs2_data <= bus.id_rs2_data;
            r_imm      <= bus.id_imm;
            r_ctrl     <= w_next_ctrl;
        end
    end

    fwd_mux #(.XLEN(XLEN)) u_fwd_a (
        .i_rs           (r_rs1),
        .i_reg_data     (r_rs1_data),
        .i_mem_rd       (bus.mem_rd),
        .i_mem_regWrite (bus.mem_regWrite),
        .i_mem_result   (bus.mem_result),
        .i_wb_rd        (bus.wb_rd),
        .i_wb_regWrite  (bus.wb_regWrite),
        .i_wb_result    (bus.wb_result),
        .o_data         (w_fwd_a)
    );

    fwd_mux #(.XLEN(XLEN)) u_fwd_b (
        .i_rs           (r_rs2),
        .i_reg_data     (r_rs2_data),
        .i_mem_rd       (bus.mem_rd),
        .i_mem_regWrite (bus.mem_regWrite),
        .i_mem_result   (bus.mem_result),
        .i_wb_rd        (bus.wb_rd),
        .i_wb_regWrite  (bus.wb_regWrite),
        .i_wb_result    (bus.wb_result),
        .o_data         (w_fwd_b)
    );

    assign bus.stall        = w_stall;
    assign bus.srcA         = r_ctrl.selPc  ? r_pc  : w_fwd_a;
    assign bus.srcB         = r_ctrl.selImm ? r_imm : w_fwd_b;
    assign bus.ex_storeData = w_fwd_b;

    assign bus.funct3       = r_ctrl.funct3;
    assign bus.funct7_6     = r_ctrl.funct7_6;
    assign bus.branch       = r_ctrl.branch;
    assign bus.useF7        = r_ctrl.useF7;
    assign bus.useRegAdd    = r_ctrl.useRegAdd;

    assign bus.ex_valid     = r_valid;
    assign bus.ex_pc        = r_pc;
    assign bus.ex_rd        = r_rd;
    assign bus.ex_regWrite  = r_ctrl.regWrite;
    assign bus.ex_memRead   = r_ctrl.memRead;
    assign bus.ex_memWrite  = r_ctrl.memWrite;

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have port clk, input, 1, single rising-edge clock.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have decode-side inputs: id_valid 1; id_pc XLEN; id_rs1, id_rs2, id_rd 5 each; id_rs1_data, id_rs2_data, id_imm XLEN; id_funct3 3; id_funct7_6, id_branch, id_useF7, id_useRegAdd, id_selPc, id_selImm, id_regWrite, id_memRead, id_memWrite 1 each.
REQ-005 SHALL have forward inputs: mem_rd 5, mem_regWrite 1, mem_result XLEN (EX/MEM stage); wb_rd 5, wb_regWrite 1, wb_result XLEN (MEM/WB stage).
REQ-006 SHALL have input flush 1, taken-branch/jump redirect that kills the instruction entering EX.
REQ-007 SHALL have output stall 1, which holds PC and the IF/ID register.
REQ-008 SHALL have ALU-side outputs: srcA, srcB XLEN; funct3 3; funct7_6, branch, useF7, useRegAdd 1 each.
REQ-009 SHALL have pass-through outputs: ex_valid 1; ex_pc XLEN; ex_rd 5; ex_regWrite, ex_memRead, ex_memWrite 1 each; ex_storeData XLEN.

Function
REQ-010 SHALL register all id_* fields into an EX register on every rising clk edge unless stall or flush modifies this.
REQ-011 SHALL assert stall combinationally when all of the following hold: id_valid; ex_valid; ex_memRead; ex_rd!=0; ex_rd matches id_rs1 or id_rs2.
REQ-012 SHALL, while stall=1, load a bubble into the EX register: ex_valid=0, ex_regWrite=0, ex_memRead=0, ex_memWrite=0, branch=0.
REQ-013 SHALL, when flush=1, load a bubble regardless of stall; flush has priority.
REQ-014 SHALL gate stall to 0 whenever flush=1.
REQ-015 SHALL resolve forwarded rs1 value fwdA with this priority:
- mem_regWrite && mem_rd!=0 && mem_rd==ex_rs1 -> mem_result
- else wb_regWrite && wb_rd!=0 && wb_rd==ex_rs1 -> wb_result
- else the registered rs1 data
REQ-016 SHALL resolve fwdB from ex_rs2 with the same rule as REQ-015.
REQ-017 SHALL drive srcA = ex_pc if selPc, else fwdA.
REQ-018 SHALL drive srcB = imm if selImm, else fwdB.
REQ-019 SHALL drive ex_storeData = fwdB.
REQ-020 SHALL make srcA, srcB and ex_storeData combinational from EX-register contents and forward inputs, giving 1-cycle latency from id_* to ALU inputs.
REQ-021 SHALL treat register x0 as never forwarded and never a hazard source.
REQ-022 SHALL pass funct3, funct7_6, branch, useF7 and useRegAdd straight from the EX register; the ALU decodes them.
REQ-023 SHALL, when id_valid=0, load a bubble (no stall generated).
REQ-024 SHALL fully compute forwarding even when ex_valid=0; consumers ignore it.
REQ-025 SHALL produce at most one bubble per load-use event; the next cycle re-evaluates with ex_memRead=0.

Reset
REQ-026 SHALL, with rst high at a clk edge, clear every EX-register flop to 0 (valid, controls, pc, data, rd).
REQ-027 SHALL hold outputs at ex_valid=0, stall=0, srcA=srcB=0 while rst is held (forward inputs also 0).
REQ-028 SHALL give rst priority over flush and stall; reset mid-stall drops the stalled instruction's bubble and produces no extra stall cycle afterwards.

Structure
REQ-029 SHALL place the forward-select enum (FWD_REG, FWD_MEM, FWD_WB) and the EX control bundle struct in the shared core package.
REQ-030 SHALL implement forwarding as one sub-module, fwd_mux, instantiated twice (rs1, rs2).

Verification
REQ-031 SHALL cover: x5=10 in ID, rs1_data=10, imm=3, selImm -> next cycle srcA=10, srcB=3, funct3 unchanged.
REQ-032 SHALL cover: mem_rd=7, mem_regWrite, mem_result=0x55, wb_rd=7, wb_result=0x99, ex_rs1=7 -> srcA=0x55.
REQ-033 SHALL cover: lw x8 in EX, add using x8 in ID -> stall=1 one cycle, bubble in EX, then add issues with x8 from wb_result.
REQ-034 SHALL cover: the REQ-033 hazard with flush=1 -> stall=0, ex_valid=0 next cycle.
REQ-035 SHALL cover: mem_rd=0, mem_regWrite=1, mem_result=0xFFFF, ex_rs1=0 -> srcA=registered value 0.
REQ-036 SHALL cover: rst asserted during stall -> all outputs 0 next cycle; first post-reset instruction propagates normally.
